// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: opcodes, immediate field widths and the
// legal range of each immediate.
package legv8_pkg;

   typedef enum logic [1:0] {
      OP_LDUR = 2'd0,
      OP_STUR = 2'd1,
      OP_CBZ  = 2'd2,
      OP_MOVZ = 2'd3
   } op_t;

   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

   localparam int D_W   = 9;
   localparam int CB_W  = 19;
   localparam int MOV_W = 16;

   localparam longint D_MIN   = -256;
   localparam longint D_MAX   = 255;
   localparam longint CB_MIN  = -262144;
   localparam longint CB_MAX  = 262143;
   localparam longint MOV_MAX = 65535;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry FIFO. Entry e0 is always the head, so when the FIFO drains the
// output keeps showing the last word that left it.
module sync_fifo2 #(
   parameter int W = 38
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] e0, e1;
   logic [1:0]   count;
   logic         pop_ok, push_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = e0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         if (push_ok && !pop_ok) begin
            if (count == 2'd0) e0 <= din;
            else               e1 <= din;
            count <= count + 2'd1;
         end else if (pop_ok && !push_ok) begin
            if (count == 2'd2) e0 <= e1;
            count <= count - 2'd1;
         end else if (push_ok && pop_ok) begin
            if (count == 2'd1) begin
               e0 <= din;
            end else begin
               e0 <= e1;
               e1 <= din;
            end
         end
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded LEGv8 fields into 32-bit instruction words, drops bundles
// whose immediate does not fit, and tags each emitted word with its address.
module instr_encoder
   import legv8_pkg::*;
#(
   parameter int N      = 64,
   parameter int ADDR_W = 6,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rn,
   input  logic [1:0]        in_hw,
   input  logic [N-1:0]      in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_valid,
   output logic [1:0]        err_op,
   output logic [ERR_W-1:0]  err_count
);

   localparam logic signed [N-1:0] LIM_D_MIN  = N'(D_MIN);
   localparam logic signed [N-1:0] LIM_D_MAX  = N'(D_MAX);
   localparam logic signed [N-1:0] LIM_CB_MIN = N'(CB_MIN);
   localparam logic signed [N-1:0] LIM_CB_MAX = N'(CB_MAX);
   localparam logic [N-1:0]        LIM_MOV    = N'(MOV_MAX);

   logic              ready_en;
   logic              s1_valid;
   op_t               s1_op;
   logic [4:0]        s1_rt, s1_rn;
   logic [1:0]        s1_hw;
   logic [N-1:0]      s1_imm;
   logic signed [N-1:0] imm_s;
   logic              in_range;
   logic [31:0]       word;
   logic [ADDR_W-1:0] addr;
   logic              push, pop, drop, retire, full, empty;

   assign imm_s = $signed(s1_imm);

   always_comb begin
      in_range = 1'b0;
      word     = '0;
      case (s1_op)
         OP_LDUR: begin
            in_range = (imm_s >= LIM_D_MIN) && (imm_s <= LIM_D_MAX);
            word     = {OPC_LDUR, s1_imm[D_W-1:0], 2'b00, s1_rn, s1_rt};
         end
         OP_STUR: begin
            in_range = (imm_s >= LIM_D_MIN) && (imm_s <= LIM_D_MAX);
            word     = {OPC_STUR, s1_imm[D_W-1:0], 2'b00, s1_rn, s1_rt};
         end
         OP_CBZ: begin
            in_range = (imm_s >= LIM_CB_MIN) && (imm_s <= LIM_CB_MAX);
            word     = {OPC_CBZ, s1_imm[CB_W-1:0], s1_rt};
         end
         OP_MOVZ: begin
            // MOVZ immediate is unsigned: any set high bit is out of range
            in_range = (s1_imm <= LIM_MOV);
            word     = {OPC_MOVZ, s1_hw, s1_imm[MOV_W-1:0], s1_rt};
         end
         default: ;
      endcase
   end

   assign pop      = !empty && out_ready;
   assign push     = s1_valid && in_range && (!full || pop);
   assign drop     = s1_valid && !in_range;
   assign retire   = push || drop;
   assign in_ready = ready_en && (!s1_valid || retire);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_en <= 1'b0;
         s1_valid <= 1'b0;
         s1_op    <= OP_LDUR;
         s1_rt    <= '0;
         s1_rn    <= '0;
         s1_hw    <= '0;
         s1_imm   <= '0;
      end else begin
         ready_en <= 1'b1;
         if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_op    <= op_t'(in_op);
            s1_rt    <= in_rt;
            s1_rn    <= in_rn;
            s1_hw    <= in_hw;
            s1_imm   <= in_imm;
         end else if (retire) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr      <= '0;
         err_valid <= 1'b0;
         err_op    <= '0;
         err_count <= '0;
      end else begin
         err_valid <= drop;
         if (push) addr <= addr + ADDR_W'(1);
         if (drop) begin
            err_op <= s1_op;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
         end
      end
   end

   sync_fifo2 #(.W(32 + ADDR_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({word, addr}),
      .dout  ({out_instr, out_addr}),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = !empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based
// reference model built from the field layouts and range rules.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [1:0]  in_op;
   logic [4:0]  in_rt, in_rn;
   logic [1:0]  in_hw;
   logic [63:0] in_imm;
   logic        out_valid, out_ready;
   logic [31:0] out_instr;
   logic [5:0]  out_addr;
   logic        err_valid;
   logic [1:0]  err_op;
   logic [7:0]  err_count;

   instr_encoder #(.N(64), .ADDR_W(6), .ERR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rt     (in_rt),
      .in_rn     (in_rn),
      .in_hw     (in_hw),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .err_valid (err_valid),
      .err_op    (err_op),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic longint lo_lim(input int op);
      case (op)
         0, 1:    return -256;
         2:       return -(longint'(1) << 18);
         default: return 0;
      endcase
   endfunction

   function automatic longint hi_lim(input int op);
      case (op)
         0, 1:    return 255;
         2:       return (longint'(1) << 18) - 1;
         default: return 65535;
      endcase
   endfunction

   function automatic logic [31:0] enc(input int op, input int rt, input int rn,
                                       input int hw, input longint imm);
      longint w;
      case (op)
         0:       w = (longint'('h7C2) << 21) | ((imm & 'h1FF) << 12) | (rn << 5) | rt;
         1:       w = (longint'('h7C0) << 21) | ((imm & 'h1FF) << 12) | (rn << 5) | rt;
         2:       w = (longint'('hB4) << 24) | ((imm & 'h7FFFF) << 5) | rt;
         default: w = (longint'('h1A5) << 23) | (hw << 21) | ((imm & 'hFFFF) << 5) | rt;
      endcase
      return w[31:0];
   endfunction

   logic [31:0] exp_instr[$];
   int          exp_addr[$];
   int          exp_err[$];
   logic [31:0] hist_instr[$];
   int          hist_addr[$];
   int          m_addr = 0;
   int          m_errcnt = 0;
   bit          rand_rdy = 0;

   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && out_ready) begin
            hist_instr.push_back(out_instr);
            hist_addr.push_back(int'(out_addr));
            if (exp_instr.size() == 0) chk("pop_unexpected", 64'(out_instr), 64'hx0);
            else begin
               chk("instr", 64'(out_instr), 64'(exp_instr.pop_front()));
               chk("addr", 64'(out_addr), 64'(exp_addr.pop_front()));
            end
         end
         if (err_valid) begin
            if (exp_err.size() == 0) chk("err_unexpected", 64'(err_valid), 64'd0);
            else begin
               if (m_errcnt < 255) m_errcnt++;
               chk("err_op", 64'(err_op), 64'(exp_err.pop_front()));
               chk("err_count", 64'(err_count), 64'(m_errcnt));
            end
         end
         if (in_valid && in_ready) begin
            if (longint'(in_imm) >= lo_lim(int'(in_op)) && longint'(in_imm) <= hi_lim(int'(in_op))) begin
               exp_instr.push_back(enc(int'(in_op), int'(in_rt), int'(in_rn), int'(in_hw), longint'(in_imm)));
               exp_addr.push_back(m_addr);
               m_addr = (m_addr + 1) % 64;
            end else begin
               exp_err.push_back(int'(in_op));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic send(input int op, input int rt, input int rn, input int hw,
                       input longint imm, output int stall);
      in_op    = 2'(op);
      in_rt    = 5'(rt);
      in_rn    = 5'(rn);
      in_hw    = 2'(hw);
      in_imm   = 64'(imm);
      in_valid = 1'b1;
      stall    = 0;
      @(negedge clk);
      while (!in_ready && stall < 50) begin
         stall++;
         @(negedge clk);
      end
      if (stall >= 50) chk("send_timeout", 64'(stall), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_instr.delete();
      exp_addr.delete();
      exp_err.delete();
      m_addr   = 0;
      m_errcnt = 0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      step(2);
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      int st, st2;
      longint imm;
      int op, kind;
      reset = 1'b0; in_valid = 1'b0; in_op = '0; in_rt = '0; in_rn = '0;
      in_hw = '0; in_imm = '0; out_ready = 1'b0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_err_valid", 64'(err_valid), 64'd0);
      chk("rst_err_op", 64'(err_op), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      step(2);
      reset = 1'b1;
      step(1);
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // first LDUR: latency and literal encoding
      out_ready = 1'b1;
      in_op = 2'd0; in_rt = 5'd1; in_rn = 5'd2; in_hw = 2'd0; in_imm = 64'd8;
      in_valid = 1'b1;
      @(negedge clk);
      chk("accept_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_s1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_out", 64'(out_valid), 64'd1);
      chk("ldur_lit", 64'(out_instr), 64'hF8408041);
      chk("ldur_addr", 64'(out_addr), 64'd0);
      step(2);

      // back-to-back STUR then CBZ
      hist_instr.delete(); hist_addr.delete();
      send(1, 3, 4, 0, -8, st);
      send(2, 5, 0, 0, -1, st2);
      chk("b2b_stall", 64'(st + st2), 64'd0);
      step(4);
      chk("stur_lit", 64'(hist_instr[0]), 64'hF81F8083);
      chk("stur_addr", 64'(hist_addr[0]), 64'd1);
      chk("cbz_lit", 64'(hist_instr[1]), 64'hB4FFFFE5);
      chk("cbz_addr", 64'(hist_addr[1]), 64'd2);

      // MOVZ in range, then out of range, then a word to confirm the address
      hist_instr.delete(); hist_addr.delete();
      send(3, 9, 0, 1, 'hBEEF, st);
      send(3, 9, 0, 1, 'h10000, st);
      step(4);
      chk("movz_lit", 64'(hist_instr[0]), 64'hD2B7DDE9);
      chk("movz_errcnt", 64'(err_count), 64'd1);
      chk("movz_err_op", 64'(err_op), 64'd3);
      chk("movz_pulse_gone", 64'(err_valid), 64'd0);
      send(0, 0, 0, 0, 0, st);
      step(4);
      chk("addr_after_drop", 64'(hist_addr[1]), 64'd4);

      // fill FIFO and S1 with the consumer stalled
      hist_instr.delete(); hist_addr.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(0, 10 + i, i, 0, i, st);
      fork
         send(0, 13, 3, 0, 3, st);
         begin
            repeat (2) @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      step(6);
      chk("fill_count", 64'(hist_addr.size()), 64'd4);
      for (int i = 0; i < 4; i++) chk("fill_addr", 64'(hist_addr[i]), 64'(5 + i));

      // LDUR range boundaries and truncation
      send(0, 1, 1, 0, 255, st);
      send(0, 1, 1, 0, 256, st);
      send(0, 1, 1, 0, -256, st);
      send(0, 1, 1, 0, -257, st);
      send(0, 1, 1, 0, 64'h1_0000_0008, st);
      send(2, 1, 0, 0, 262144, st);
      send(2, 1, 0, 0, -262145, st);
      step(4);
      chk("bound_errcnt", 64'(err_count), 64'd6);

      // error counter saturation
      for (int i = 0; i < 260; i++) send(0, 2, 2, 0, 256, st);
      step(4);
      chk("err_sat", 64'(err_count), 64'd255);

      // randomized traffic with random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op   = int'($urandom_range(0, 3));
         kind = int'($urandom_range(0, 5));
         case (kind)
            0, 1: imm = lo_lim(op) + longint'($urandom_range(0, 32'(hi_lim(op) - lo_lim(op))));
            2:    imm = lo_lim(op);
            3:    imm = hi_lim(op);
            4:    imm = ($urandom_range(0, 1) != 0) ? lo_lim(op) - 1 : hi_lim(op) + 1;
            default: imm = longint'({$urandom, $urandom});
         endcase
         send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), imm, st);
      end
      rand_rdy = 1'b0;
      step(1);
      out_ready = 1'b1;
      step(8);
      chk("drain_words", 64'(exp_instr.size()), 64'd0);
      chk("drain_errs", 64'(exp_err.size()), 64'd0);

      // reset with two words pending
      out_ready = 1'b0;
      send(0, 4, 4, 0, 4, st);
      send(0, 5, 5, 0, 5, st);
      step(2);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      do_reset();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      hist_instr.delete(); hist_addr.delete();
      out_ready = 1'b1;
      send(1, 6, 7, 0, 16, st);
      step(4);
      chk("post_rst_count", 64'(hist_addr.size()), 64'd1);
      chk("post_rst_addr", 64'(hist_addr[0]), 64'd0);
      chk("post_rst_errcnt", 64'(err_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
